// File: rtl/boreal_spatial_projector.sv
// boreal_spatial_projector: weights a channel-multiplexed sample stream,
// reduces each frame to a saturated X/Y feature pair on a valid/ready port.
module boreal_spatial_projector #(
    parameter int CHANNELS  = 8,
    parameter int CH_W      = 3,
    parameter int SAMPLE_W  = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic        [CH_W-1:0]     channel_sel,
    input  logic                       sample_valid,
    input  logic                       coef_we,
    input  logic                       coef_axis,
    input  logic        [CH_W-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic signed [SAMPLE_W-1:0] feature_x,
    output logic signed [SAMPLE_W-1:0] feature_y,
    output logic                       feature_valid,
    input  logic                       feature_ready,
    output logic                       sat_flag,
    output logic                       seq_err,
    output logic                       frame_drop
);

    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam int DEPTH  = 1 << CH_W;

    localparam logic [CH_W:0]   CH_LIMIT = (CH_W+1)'(CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [CH_W-1:0] FIRST_CH = '0;
    localparam logic [CH_W-1:0] NEXT_CH  = CH_W'(1);

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_RESYNC = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Weight file
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0] w_x [DEPTH];
    logic signed [COEF_W-1:0] w_y [DEPTH];
    logic                     coef_hit;

    assign coef_hit = coef_we && ({1'b0, coef_addr} < CH_LIMIT);

    // Weight writes; entries past CHANNELS are never written and stay zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_x[i] <= '0;
                w_y[i] <= '0;
            end
        end else if (coef_hit) begin
            if (coef_axis) begin
                w_y[coef_addr] <= coef_data;
            end else begin
                w_x[coef_addr] <= coef_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: multiply
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0]   wx_sel;
    logic signed [COEF_W-1:0]   wy_sel;
    logic signed [PROD_W-1:0]   smp_ext;
    logic signed [PROD_W-1:0]   wx_ext;
    logic signed [PROD_W-1:0]   wy_ext;

    logic                       s1_valid;
    logic        [CH_W-1:0]     s1_ch;
    logic signed [PROD_W-1:0]   s1_px;
    logic signed [PROD_W-1:0]   s1_py;

    assign wx_sel  = w_x[channel_sel];
    assign wy_sel  = w_y[channel_sel];
    assign smp_ext = {{COEF_W{sample_in[SAMPLE_W-1]}}, sample_in};
    assign wx_ext  = {{SAMPLE_W{wx_sel[COEF_W-1]}}, wx_sel};
    assign wy_ext  = {{SAMPLE_W{wy_sel[COEF_W-1]}}, wy_sel};

    // Register both products; the weight read sees pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_px    <= '0;
            s1_py    <= '0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                s1_ch <= channel_sel;
                s1_px <= smp_ext * wx_ext;
                s1_py <= smp_ext * wy_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: frame accumulation and sequence tracking
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] px_acc;
    logic signed [ACC_W-1:0] py_acc;

    assign px_acc = {{(ACC_W-PROD_W){s1_px[PROD_W-1]}}, s1_px};
    assign py_acc = {{(ACC_W-PROD_W){s1_py[PROD_W-1]}}, s1_py};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
    logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
    logic        [CH_W-1:0]  expected_ch_q, expected_ch_d;
    logic signed [ACC_W-1:0] sum_x_q, sum_x_d;
    logic signed [ACC_W-1:0] sum_y_q, sum_y_d;
    logic                    done_q, done_d;
    logic                    serr_q, serr_d;

    // Next-state logic: accumulate in order, close frames, resync on errors.
    always_comb begin
        state_d       = state_q;
        acc_x_d       = acc_x_q;
        acc_y_d       = acc_y_q;
        expected_ch_d = expected_ch_q;
        sum_x_d       = sum_x_q;
        sum_y_d       = sum_y_q;
        done_d        = 1'b0;
        serr_d        = 1'b0;
        if (s1_valid) begin
            case (state_q)
                ST_ACCUM: begin
                    if (s1_ch == expected_ch_q) begin
                        if (expected_ch_q == LAST_CH) begin
                            sum_x_d       = acc_x_q + px_acc;
                            sum_y_d       = acc_y_q + py_acc;
                            done_d        = 1'b1;
                            acc_x_d       = '0;
                            acc_y_d       = '0;
                            expected_ch_d = FIRST_CH;
                        end else begin
                            acc_x_d       = acc_x_q + px_acc;
                            acc_y_d       = acc_y_q + py_acc;
                            expected_ch_d = expected_ch_q + NEXT_CH;
                        end
                    end else begin
                        serr_d = 1'b1;
                        if (s1_ch == FIRST_CH) begin
                            acc_x_d       = px_acc;
                            acc_y_d       = py_acc;
                            expected_ch_d = NEXT_CH;
                        end else begin
                            acc_x_d       = '0;
                            acc_y_d       = '0;
                            expected_ch_d = FIRST_CH;
                            state_d       = ST_RESYNC;
                        end
                    end
                end
                ST_RESYNC: begin
                    if (s1_ch == FIRST_CH) begin
                        acc_x_d       = px_acc;
                        acc_y_d       = py_acc;
                        expected_ch_d = NEXT_CH;
                        state_d       = ST_ACCUM;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    // Stage-2 state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ACCUM;
            acc_x_q       <= '0;
            acc_y_q       <= '0;
            expected_ch_q <= '0;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            done_q        <= 1'b0;
            serr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_x_q       <= acc_x_d;
            acc_y_q       <= acc_y_d;
            expected_ch_q <= expected_ch_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
            done_q        <= done_d;
            serr_q        <= serr_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: scale, saturate and hold for the consumer
    // ------------------------------------------------------------------
    function automatic logic [SAMPLE_W:0] clip(
        input logic signed [ACC_W-1:0] sum
    );
        logic signed [ACC_W-1:0] sh;
        sh = sum >>> OUT_SHIFT;
        if (sh > OUT_MAX) begin
            clip = {1'b1, OUT_MAX[SAMPLE_W-1:0]};
        end else if (sh < OUT_MIN) begin
            clip = {1'b1, OUT_MIN[SAMPLE_W-1:0]};
        end else begin
            clip = {1'b0, sh[SAMPLE_W-1:0]};
        end
    endfunction

    logic [SAMPLE_W:0] clip_x;
    logic [SAMPLE_W:0] clip_y;
    logic              out_free;

    // Floor-shift and clip both frame sums.
    always_comb begin
        clip_x = clip(sum_x_q);
        clip_y = clip(sum_y_q);
    end

    assign out_free = !feature_valid || feature_ready;

    // Output holding register plus the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feature_x     <= '0;
            feature_y     <= '0;
            sat_flag      <= 1'b0;
            feature_valid <= 1'b0;
            seq_err       <= 1'b0;
            frame_drop    <= 1'b0;
        end else begin
            seq_err    <= serr_q;
            frame_drop <= done_q && !out_free;
            if (done_q && out_free) begin
                feature_x     <= clip_x[SAMPLE_W-1:0];
                feature_y     <= clip_y[SAMPLE_W-1:0];
                sat_flag      <= clip_x[SAMPLE_W] | clip_y[SAMPLE_W];
                feature_valid <= 1'b1;
            end else if (feature_ready) begin
                feature_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_boreal_spatial_projector.sv
// tb_boreal_spatial_projector: vector table plus scoreboard bench for the
// spatial projector, with hand-written sequence/back-pressure/reset cases.
module tb_boreal_spatial_projector;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] sample_in;
    logic        [2:0]  channel_sel;
    logic               sample_valid;
    logic               coef_we;
    logic               coef_axis;
    logic        [2:0]  coef_addr;
    logic signed [15:0] coef_data;
    logic signed [15:0] feature_x;
    logic signed [15:0] feature_y;
    logic               feature_valid;
    logic               feature_ready;
    logic               sat_flag;
    logic               seq_err;
    logic               frame_drop;

    always #5 clk = ~clk;

    boreal_spatial_projector #(
        .CHANNELS (8),
        .CH_W     (3),
        .SAMPLE_W (16),
        .COEF_W   (16),
        .ACC_W    (40),
        .OUT_SHIFT(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .channel_sel  (channel_sel),
        .sample_valid (sample_valid),
        .coef_we      (coef_we),
        .coef_axis    (coef_axis),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .feature_x    (feature_x),
        .feature_y    (feature_y),
        .feature_valid(feature_valid),
        .feature_ready(feature_ready),
        .sat_flag     (sat_flag),
        .seq_err      (seq_err),
        .frame_drop   (frame_drop)
    );

    typedef struct {
        int wx0;
        int wx;
        int wy;
        int s0;
        int smp;
        int ex;
        int ey;
        bit esat;
    } vec_t;

    typedef struct {
        int x;
        int y;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_errors = 0;
    int   seq_cnt  = 0;
    int   drop_cnt = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard: every accepted feature pair must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (seq_err) seq_cnt++;
            if (frame_drop) drop_cnt++;
            if (feature_valid && feature_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got x=%0d y=%0d, required none",
                             feature_x, feature_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("feature_x", feature_x, mon_e.x);
                    chk("feature_y", feature_y, mon_e.y);
                    chk("sat_flag", sat_flag, mon_e.sat);
                end
            end
        end
    end

    task automatic put(input int ch, input int v);
        sample_valid = 1'b1;
        channel_sel  = 3'(ch);
        sample_in    = 16'(v);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic write_coef(input bit axis, input int addr, input int v);
        coef_we   = 1'b1;
        coef_axis = axis;
        coef_addr = 3'(addr);
        coef_data = 16'(v);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic load_weights(input int wx0, input int wx, input int wy);
        for (int c = 0; c < 8; c++) begin
            write_coef(1'b0, c, (c == 0) ? wx0 : wx);
            write_coef(1'b1, c, wy);
        end
    endtask

    task automatic send_frame(input int s0, input int smp);
        put(0, s0);
        for (int c = 1; c < 8; c++) put(c, smp);
    endtask

    task automatic push_exp(input int x, input int y, input bit sat);
        exp_t e;
        e.x   = x;
        e.y   = y;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        sample_in     = '0;
        channel_sel   = '0;
        sample_valid  = 1'b0;
        coef_we       = 1'b0;
        coef_axis     = 1'b0;
        coef_addr     = '0;
        coef_data     = '0;
        feature_ready = 1'b1;

        vecs[0] = '{8192, 8192, 0, 1000, 1000, 1000, 0, 1'b0};
        vecs[1] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 1'b1};
        vecs[2] = '{32767, 32767, 32767, -32768, -32768, -32768, -32768, 1'b1};
        vecs[3] = '{1, 0, 0, -1, 0, -1, 0, 1'b0};
        vecs[4] = '{-8192, -8192, 4096, 2000, 2000, -2000, 1000, 1'b0};
        vecs[5] = '{16384, 16384, -16384, -3, -3, -6, 6, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", feature_valid, 0);
        chk("reset_x", feature_x, 0);
        chk("reset_y", feature_y, 0);
        chk("reset_sat", sat_flag, 0);
        chk("reset_seq_err", seq_err, 0);
        chk("reset_frame_drop", frame_drop, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors with latency check on every frame.
        foreach (vecs[i]) begin
            load_weights(vecs[i].wx0, vecs[i].wx, vecs[i].wy);
            push_exp(vecs[i].ex, vecs[i].ey, vecs[i].esat);
            send_frame(vecs[i].s0, vecs[i].smp);
            @(negedge clk);
            chk("lat_t0", feature_valid, 0);
            @(negedge clk);
            chk("lat_t1", feature_valid, 0);
            @(negedge clk);
            chk("lat_t2", feature_valid, 1);
            @(negedge clk);
            chk("valid_one_cycle", feature_valid, 0);
            drain("vec_drain");
        end

        // Sequence error then ignored channels, then a clean frame.
        load_weights(8192, 8192, 0);
        seq_cnt  = 0;
        drop_cnt = 0;
        put(0, 1000);
        put(1, 1000);
        put(3, 1000);
        put(5, 1000);
        put(6, 1000);
        push_exp(1000, 0, 1'b0);
        send_frame(1000, 1000);
        repeat (6) @(posedge clk);
        drain("seq_drain");
        chk("seq_err_count", seq_cnt, 1);

        // Out-of-order channel 0 restarts the frame directly.
        seq_cnt = 0;
        put(0, 1000);
        put(1, 1000);
        push_exp(1000, 0, 1'b0);
        send_frame(1000, 1000);
        repeat (6) @(posedge clk);
        drain("restart_drain");
        chk("restart_seq_err_count", seq_cnt, 1);
        chk("seq_frame_drop_count", drop_cnt, 0);

        // Back-pressure across two back-to-back frames.
        feature_ready = 1'b0;
        drop_cnt      = 0;
        push_exp(1000, 0, 1'b0);
        send_frame(1000, 1000);
        send_frame(2000, 2000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_valid_held", feature_valid, 1);
        chk("bp_x_held", feature_x, 1000);
        chk("bp_drop_count", drop_cnt, 1);
        @(posedge clk);
        #1;
        feature_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_fall", feature_valid, 0);
        drain("bp_drain");

        // Weight write colliding with channel 3 uses the old weight.
        push_exp(1000, 0, 1'b0);
        push_exp(1125, 0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            sample_valid = 1'b1;
            channel_sel  = 3'(c);
            sample_in    = 16'sd1000;
            coef_we      = (c == 3);
            coef_axis    = 1'b0;
            coef_addr    = 3'd3;
            coef_data    = 16'sd16384;
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        send_frame(1000, 1000);
        repeat (6) @(posedge clk);
        drain("wtime_drain");
        write_coef(1'b0, 3, 8192);

        // Reset mid-frame with an output held pending.
        feature_ready = 1'b0;
        send_frame(1000, 1000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", feature_valid, 1);
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) put(c, 1000);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", feature_valid, 0);
        chk("midrst_x", feature_x, 0);
        chk("midrst_y", feature_y, 0);
        chk("midrst_sat", sat_flag, 0);
        chk("midrst_seq_err", seq_err, 0);
        chk("midrst_frame_drop", frame_drop, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        feature_ready = 1'b1;
        seq_cnt       = 0;
        drop_cnt      = 0;
        push_exp(0, 0, 1'b0);
        send_frame(1000, 1000);
        repeat (6) @(posedge clk);
        drain("zero_w_drain");
        load_weights(8192, 8192, 0);
        push_exp(1000, 0, 1'b0);
        send_frame(1000, 1000);
        repeat (6) @(posedge clk);
        drain("post_rst_drain");
        chk("post_rst_seq_err", seq_cnt, 0);
        chk("post_rst_drop", drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
